// File: rtl/rom_load_pkg.sv
// Shared constants and types for the Phoenix ROM download sequencer.
package rom_load_pkg;

    localparam logic [15:0] PROG_BASE  = 16'h0000;
    localparam logic [15:0] PROG_LIMIT = 16'h3FFF;
    localparam logic [15:0] FG_BASE    = 16'h4000;
    localparam logic [15:0] FG_LIMIT   = 16'h4FFF;
    localparam logic [15:0] BG_BASE    = 16'h5000;
    localparam logic [15:0] BG_LIMIT   = 16'h5FFF;
    localparam logic [15:0] PROM_BASE  = 16'h6000;
    localparam logic [15:0] PROM_LIMIT = 16'h61FF;

    localparam int DEFAULT_EXPECTED_SIZE = 25088;

    localparam int REGION_PROG = 0;
    localparam int REGION_FG   = 1;
    localparam int REGION_BG   = 2;
    localparam int REGION_PROM = 3;
    localparam int NUM_REGIONS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        FAULT
    } load_state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Maps a download byte address onto one of the four ROM regions,
// giving a one-hot select, the region-relative offset and an out-of-range flag.
module rom_region_decode
    import rom_load_pkg::*;
(
    input  logic [15:0]            i_addr,
    output logic [NUM_REGIONS-1:0] o_sel,
    output logic [13:0]            o_offset,
    output logic                   o_out_of_range
);

    always_comb begin
        o_sel          = '0;
        o_offset       = '0;
        o_out_of_range = 1'b0;
        if (i_addr <= PROG_LIMIT) begin
            o_sel[REGION_PROG] = 1'b1;
            o_offset           = 14'(i_addr - PROG_BASE);
        end else if (i_addr <= FG_LIMIT) begin
            o_sel[REGION_FG] = 1'b1;
            o_offset         = 14'(i_addr - FG_BASE);
        end else if (i_addr <= BG_LIMIT) begin
            o_sel[REGION_BG] = 1'b1;
            o_offset         = 14'(i_addr - BG_BASE);
        end else if (i_addr <= PROM_LIMIT) begin
            o_sel[REGION_PROM] = 1'b1;
            o_offset           = 14'(i_addr - PROM_BASE);
        end else begin
            o_out_of_range = 1'b1;
        end
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequencer between the HPS ROM download stream and the Phoenix core: decodes
// bytes into region write strobes, validates the image and gates core reset.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int EXPECTED_SIZE = DEFAULT_EXPECTED_SIZE,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        wr_prog,
    output logic        wr_fg,
    output logic        wr_bg,
    output logic        wr_prom,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic [15:0] byte_count
);

    localparam int              CW             = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [16:0]     LP_EXPECTED    = 17'(EXPECTED_SIZE);
    localparam logic [CW-1:0]   LP_SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    load_state_t              r_state;
    load_state_t              w_next_state;
    logic [CW-1:0]            r_settle_cnt;
    logic                     r_seq_err;
    logic [15:0]              r_byte_count;
    logic                     r_load_ok;
    logic                     r_load_err;
    logic [NUM_REGIONS-1:0]   r_wr_sel;
    logic [13:0]              r_wr_addr;
    logic [7:0]               r_wr_data;

    logic                     w_enter_load;
    logic                     w_accept;
    logic [15:0]              w_count_base;
    logic                     w_seq_base;
    logic                     w_oor;
    logic                     w_addr_bad;
    logic [NUM_REGIONS-1:0]   w_dec_sel;
    logic [13:0]              w_dec_offset;
    logic                     w_dec_oor;

    rom_region_decode u_decode (
        .i_addr         (dn_addr),
        .o_sel          (w_dec_sel),
        .o_offset       (w_dec_offset),
        .o_out_of_range (w_dec_oor)
    );

    // A write arriving on the first download cycle is counted against a freshly cleared image.
    assign w_accept     = dn_download & dn_wr;
    assign w_count_base = w_enter_load ? 16'd0 : r_byte_count;
    assign w_seq_base   = w_enter_load ? 1'b0 : r_seq_err;
    assign w_oor        = w_dec_oor | ({1'b0, dn_addr} >= LP_EXPECTED);
    assign w_addr_bad   = (dn_addr != w_count_base);

    always_comb begin
        w_next_state = r_state;
        w_enter_load = 1'b0;
        if (dn_download) begin
            w_next_state = LOAD;
            w_enter_load = (r_state != LOAD);
        end else begin
            case (r_state)
                LOAD: begin
                    if (({1'b0, r_byte_count} == LP_EXPECTED) && !r_seq_err)
                        w_next_state = SETTLE;
                    else
                        w_next_state = FAULT;
                end
                SETTLE: begin
                    if (r_settle_cnt == '0)
                        w_next_state = RUN;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_seq_err    <= 1'b0;
            r_byte_count <= '0;
            r_load_ok    <= 1'b0;
            r_load_err   <= 1'b0;
            r_wr_sel     <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_wr_sel <= '0;
            if (w_enter_load) begin
                r_byte_count <= '0;
                r_load_ok    <= 1'b0;
                r_load_err   <= 1'b0;
                r_seq_err    <= 1'b0;
            end
            if (w_accept) begin
                r_byte_count <= (w_count_base == 16'hFFFF) ? w_count_base : w_count_base + 16'd1;
                r_seq_err    <= w_seq_base | w_addr_bad | w_oor;
                r_wr_addr    <= w_dec_offset;
                r_wr_data    <= dn_data;
                if (!w_oor)
                    r_wr_sel <= w_dec_sel;
            end
            if (r_state == LOAD && w_next_state == FAULT)
                r_load_err <= 1'b1;
            if (r_state == LOAD && w_next_state == SETTLE)
                r_settle_cnt <= LP_SETTLE_LOAD;
            else if (r_state == SETTLE && r_settle_cnt != '0)
                r_settle_cnt <= r_settle_cnt - CW'(1);
            if (r_state == SETTLE && w_next_state == RUN)
                r_load_ok <= 1'b1;
        end
    end

    assign wr_prog    = r_wr_sel[REGION_PROG];
    assign wr_fg      = r_wr_sel[REGION_FG];
    assign wr_bg      = r_wr_sel[REGION_BG];
    assign wr_prom    = r_wr_sel[REGION_PROM];
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign core_reset = (r_state != RUN);
    assign load_ok    = r_load_ok;
    assign load_err   = r_load_err;
    assign byte_count = r_byte_count;

endmodule

// File: doc/rom_load_ctrl.md
# rom_load_ctrl

Sequencer between the HPS ROM download stream and the Phoenix core. It decodes each downloaded byte into a write strobe for one of four on-chip ROM regions and checks that the image is complete and in order. It holds the core in reset until a valid image has loaded and a settle delay has elapsed. It sits in the emu top level, between hps_io's ioctl outputs and the phoenix instance's ROM write ports and reset input.

## Interface
Parameters:
- EXPECTED_SIZE, 25088 (0x6200): exact byte count of a valid image.
- SETTLE_CYCLES, 16: clk cycles that core_reset stays high after a good load.

Ports (one clock domain; reset is synchronous and active-high):
- clk  in  1  system clock (clk_sys, 11 MHz)
- reset  in  1  synchronous, active-high; covers RESET, the OSD reset bit and the reset button
- dn_download  in  1  download window active
- dn_wr  in  1  one-cycle byte-valid strobe
- dn_addr  in  16  byte address within the image
- dn_data  in  8  byte value
- wr_prog  out  1  write strobe, program ROM (0x0000–0x3FFF)
- wr_fg  out  1  write strobe, foreground gfx (0x4000–0x4FFF)
- wr_bg  out  1  write strobe, background gfx (0x5000–0x5FFF)
- wr_prom  out  1  write strobe, colour PROMs (0x6000–0x61FF)
- wr_addr  out  14  region-relative address (dn_addr − region base)
- wr_data  out  8  registered dn_data
- core_reset  out  1  reset request to the core
- load_ok  out  1  the last download completed and validated
- load_err  out  1  the last download failed validation
- byte_count  out  16  bytes accepted in the current or last download; saturates at 0xFFFF

## Operation
- FSM states: IDLE, LOAD, SETTLE, RUN, FAULT.
- IDLE:
  - Entered from reset; no image is present.
  - core_reset=1.
- Any state, dn_download=1 → LOAD (also covers a re-download from RUN or FAULT). Entry to LOAD performs these clears:
  - byte_count=0
  - load_ok=0
  - load_err=0
  - internal seq_err=0
- LOAD, on each dn_wr=1:
  - byte_count increments.
  - If dn_addr ≠ byte_count (pre-increment value), seq_err=1.
  - If dn_addr ≥ EXPECTED_SIZE, no strobe is issued and seq_err=1.
  - Otherwise exactly one region strobe is issued.
- LOAD, on dn_download falling:
  - If byte_count == EXPECTED_SIZE and seq_err=0 → SETTLE, with the settle counter loaded to SETTLE_CYCLES−1.
  - Otherwise → FAULT, with load_err=1.
- SETTLE:
  - Counts down to 0, then → RUN.
  - load_ok is set on entry to RUN.
- RUN: core_reset=0.
- FAULT: core_reset=1. Exit only through a new download.
- core_reset=1 in every state except RUN.
- A dn_wr while dn_download=0 is ignored: no strobe, no count.
- dn_wr in the same cycle as dn_download falling is ignored. dn_download is sampled first.

## Timing
- Reset values:
  - State IDLE.
  - All wr_* strobes 0.
  - wr_addr=0, wr_data=0.
  - core_reset=1.
  - load_ok=0, load_err=0.
  - byte_count=0.
- Write path latency is 1 cycle: dn_wr at cycle n gives a strobe, wr_addr and wr_data at cycle n+1. Each strobe lasts one cycle.
- Back-to-back dn_wr on consecutive cycles is supported at full rate.
- dn_download falling at cycle n → the state changes at cycle n+1.
- After a good load, core_reset falls at cycle n+1+SETTLE_CYCLES.
- Reset during LOAD returns to IDLE. The partial image is discarded and core_reset stays high until the next full download.

## Structure
- Package rom_load_pkg holds:
  - the region base and limit constants (PROG, FG, BG, PROM);
  - the default EXPECTED_SIZE;
  - the FSM state enum.
- Sub-module rom_region_decode: combinational dn_addr → one-hot region select, 14-bit offset and out_of_range flag. It is instantiated once, and its outputs are registered in rom_load_ctrl.

## Test plan
- Full load: addresses 0..0x61FF sequential with data = addr[7:0].
  - Exactly 0x4000 wr_prog, 0x1000 wr_fg, 0x1000 wr_bg and 0x200 wr_prom pulses.
  - Address 0x5003 gives wr_bg, wr_addr=0x003, wr_data=0x03.
  - load_ok=1, and core_reset falls 17 cycles after dn_download falls.
- Short load of 0x6100 bytes → FAULT: load_err=1, core_reset stays 1, byte_count=0x6100.
- Out-of-order load where address 0x0010 is sent twice → load_err=1, even though the total count equals EXPECTED_SIZE.
- A byte at address 0x6200 → no strobe, load_err=1 at the end.
- Reset asserted mid-LOAD at byte 0x1234 → IDLE with byte_count=0 and core_reset=1. A following full load succeeds.
- Re-download from RUN:
  - core_reset rises the cycle after dn_download rises.
  - load_ok clears.
  - A stray dn_wr with dn_download=0 produces no strobe.
